// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data-cache controller.
// The line tag is sized for the smallest legal index so any SETS/ADDR_W up to 32 bits fits.
package dcache_pkg;

   localparam int DEF_SETS   = 64;
   localparam int DEF_ADDR_W = 32;
   localparam int INDEX_W    = $clog2(DEF_SETS);
   localparam int TAG_W      = DEF_ADDR_W - 2 - INDEX_W;
   // Widest tag needed at the minimum index width of 1; narrower tags are zero-extended.
   localparam int LINE_TAG_W = TAG_W + INDEX_W - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WRITEBACK,
      ST_REFILL,
      ST_RESPOND
   } cache_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  dirty;
      logic [LINE_TAG_W-1:0] tag;
      logic [31:0]           data;
   } cache_line_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_way_array.sv
// Tag/data/valid/dirty storage: one combinational read port returning every way of a set,
// one synchronous write port for a single way.
module dcache_way_array
   import dcache_pkg::*;
#(
   parameter  int SETS  = 64,
   parameter  int WAYS  = 2,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [IDX_W-1:0] rd_index_i,
   output cache_line_t      rd_lines_o [WAYS],
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_index_i,
   input  logic [WAY_W-1:0] wr_way_i,
   input  cache_line_t      wr_line_i
);

   cache_line_t lines_q [SETS][WAYS];

   // NOTE: the array is reset because valid/dirty must clear asynchronously; a plain RAM
   // without reset could not invalidate every line at once.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) lines_q[s][w] <= '0;
         end
      end else if (wr_en_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (wr_way_i == WAY_W'(w)) lines_q[wr_index_i][w] <= wr_line_i;
         end
      end
   end

   always_comb begin
      for (int w = 0; w < WAYS; w++) rd_lines_o[w] = lines_q[rd_index_i][w];
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Set-associative write-back/write-allocate data-cache controller: one request in flight,
// round-robin replacement, fixed-latency memory, saturating hit/miss counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int SETS        = DEF_SETS,
   parameter int WAYS        = 2,
   parameter int MEM_LATENCY = 4,
   parameter int ADDR_W      = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_byte_en,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data_in  [0:3],
   input  logic [7:0]        mem_data_out [0:3],
   output logic              mem_write_en,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IDX_W     = $clog2(SETS);
   localparam int REQ_TAG_W = ADDR_W - 2 - IDX_W;
   localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int CNT_W     = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   cache_state_t      state_q, state_d;
   logic              write_q;
   logic [ADDR_W-1:2] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic [WAY_W-1:0]  victim_q, victim_d;
   logic              victim_valid_q, victim_valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_word_q, mem_word, mem_word_in;
   logic [31:0]       hit_count_q, miss_count_q;
   logic              hit_inc, miss_inc;
   logic [WAY_W-1:0]  rr_q [SETS];
   logic              rr_adv;
   logic              accept;
   logic [1:0]        unused_offset;

   logic [IDX_W-1:0]      req_index;
   logic [REQ_TAG_W-1:0]  req_tag;
   logic [LINE_TAG_W-1:0] req_tag_ext;
   cache_line_t           rd_lines [WAYS];
   logic                  wr_en;
   logic [WAY_W-1:0]      wr_way;
   cache_line_t           wr_line;

   logic                 hit, inv_found;
   logic [WAY_W-1:0]     hit_way, inv_way, victim_c, sel_way;
   logic [31:0]          hit_data, vict_data, merged_hit, merged_fill;
   logic                 vict_valid, vict_dirty;
   logic [REQ_TAG_W-1:0] vict_tag;

   assign unused_offset = req_addr[1:0];
   assign req_index     = addr_q[2 +: IDX_W];
   assign req_tag       = addr_q[ADDR_W-1 -: REQ_TAG_W];
   assign req_tag_ext   = LINE_TAG_W'(req_tag);
   assign accept        = req_valid && req_ready;

   dcache_way_array #(
      .SETS (SETS),
      .WAYS (WAYS)
   ) u_way_array (
      .clk        (clk),
      .rst_b      (rst_b),
      .rd_index_i (req_index),
      .rd_lines_o (rd_lines),
      .wr_en_i    (wr_en),
      .wr_index_i (req_index),
      .wr_way_i   (wr_way),
      .wr_line_i  (wr_line)
   );

   // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
   // which is what keeps combinational blocks from inferring latches.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      hit_data  = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (rd_lines[w].valid && (rd_lines[w].tag == req_tag_ext)) begin
            hit      = 1'b1;
            hit_way  = WAY_W'(w);
            hit_data = rd_lines[w].data;
         end
         if (!rd_lines[w].valid && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   // The victim is chosen in LOOKUP and then frozen in victim_q for WRITEBACK/REFILL.
   assign victim_c = inv_found ? inv_way : rr_q[req_index];
   assign sel_way  = (state_q == ST_LOOKUP) ? victim_c : victim_q;

   always_comb begin
      vict_valid = 1'b0;
      vict_dirty = 1'b0;
      vict_tag   = '0;
      vict_data  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (sel_way == WAY_W'(w)) begin
            vict_valid = rd_lines[w].valid;
            vict_dirty = rd_lines[w].dirty;
            vict_tag   = rd_lines[w].tag[REQ_TAG_W-1:0];
            vict_data  = rd_lines[w].data;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) mem_word_in[8*i +: 8] = mem_data_out[i];
   end

   assign merged_hit  = merge_bytes(hit_data, wdata_q, be_q);
   assign merged_fill = merge_bytes(mem_word_in, wdata_q, be_q);

   always_comb begin
      state_d        = state_q;
      victim_d       = victim_q;
      victim_valid_d = victim_valid_q;
      cnt_d          = cnt_q;
      resp_data_d    = resp_data_q;
      wr_en          = 1'b0;
      wr_way         = victim_q;
      wr_line        = '0;
      hit_inc        = 1'b0;
      miss_inc       = 1'b0;
      rr_adv         = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (hit) begin
               hit_inc     = 1'b1;
               resp_data_d = merged_hit;
               wr_en       = write_q;
               wr_way      = hit_way;
               wr_line     = '{valid: 1'b1, dirty: 1'b1, tag: req_tag_ext, data: merged_hit};
               state_d     = ST_RESPOND;
            end else begin
               miss_inc       = 1'b1;
               victim_d       = victim_c;
               victim_valid_d = vict_valid;
               cnt_d          = '0;
               state_d        = (vict_valid && vict_dirty) ? ST_WRITEBACK : ST_REFILL;
            end
         end
         ST_WRITEBACK: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_REFILL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REFILL: begin
            if (cnt_q == CNT_LAST) begin
               wr_en       = 1'b1;
               wr_line     = '{valid: 1'b1, dirty: write_q, tag: req_tag_ext, data: merged_fill};
               resp_data_d = merged_fill;
               rr_adv      = victim_valid_q;
               state_d     = ST_RESPOND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Memory-side outputs are decoded from state so reset removes the write strobe at once.
   always_comb begin
      mem_addr     = mem_addr_q;
      mem_word     = mem_word_q;
      mem_write_en = 1'b0;
      if (state_q == ST_WRITEBACK) begin
         mem_addr     = {vict_tag, req_index, 2'b00};
         mem_word     = vict_data;
         mem_write_en = 1'b1;
      end else if (state_q == ST_REFILL) begin
         mem_addr = {addr_q, 2'b00};
      end
      for (int i = 0; i < 4; i++) mem_data_in[i] = mem_word[8*i +: 8];
   end

   assign req_ready  = rst_b && (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESPOND);
   assign resp_rdata = resp_data_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q        <= ST_IDLE;
         write_q        <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         be_q           <= '0;
         victim_q       <= '0;
         victim_valid_q <= 1'b0;
         cnt_q          <= '0;
         resp_data_q    <= '0;
         mem_addr_q     <= '0;
         mem_word_q     <= '0;
         hit_count_q    <= '0;
         miss_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         victim_q       <= victim_d;
         victim_valid_q <= victim_valid_d;
         cnt_q          <= cnt_d;
         resp_data_q    <= resp_data_d;
         mem_addr_q     <= mem_addr;
         mem_word_q     <= mem_word;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            // Loads carry no enables so the shared merge path leaves their data untouched.
            be_q    <= req_write ? req_byte_en : 4'b0000;
         end
         if (hit_inc && (hit_count_q != '1))   hit_count_q  <= hit_count_q + 1'b1;
         if (miss_inc && (miss_count_q != '1)) miss_count_q <= miss_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (rr_adv) begin
         rr_q[req_index] <= (WAYS == 1) ? '0 : rr_q[req_index] + 1'b1;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench: a 2-way cache for the main scenarios and a direct-mapped build for
// the conflict-miss case, each with its own fixed-latency memory model.
module tb_dcache_ctrl;

   localparam int LAT = 4;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          len;
   } wb_t;

   logic clk;
   logic rst_b;
   int   cyc;
   int   checks;
   int   errors;

   logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_mem_we;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_addr, a_hits, a_misses;
   logic [3:0]  a_req_be;
   logic [7:0]  a_mem_din  [0:3];
   logic [7:0]  a_mem_dout [0:3];

   logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_mem_we;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_mem_addr, b_hits, b_misses;
   logic [3:0]  b_req_be;
   logic [7:0]  b_mem_din  [0:3];
   logic [7:0]  b_mem_dout [0:3];

   exp_t        q_a[$];
   exp_t        q_b[$];
   wb_t         wb_log[$];
   logic [31:0] mem_a [logic [31:0]];
   logic [31:0] mem_b [logic [31:0]];
   int          a_issued, a_resp_cnt;
   logic [31:0] wb_addr, wb_data;
   int          wb_len;

   dcache_ctrl #(.SETS(64), .WAYS(2), .MEM_LATENCY(LAT), .ADDR_W(32)) u_dut_a (
      .clk (clk), .rst_b (rst_b),
      .req_valid (a_req_valid), .req_ready (a_req_ready), .req_write (a_req_write),
      .req_addr (a_req_addr), .req_wdata (a_req_wdata), .req_byte_en (a_req_be),
      .resp_valid (a_resp_valid), .resp_rdata (a_resp_rdata),
      .mem_addr (a_mem_addr), .mem_data_in (a_mem_din), .mem_data_out (a_mem_dout),
      .mem_write_en (a_mem_we), .hit_count (a_hits), .miss_count (a_misses)
   );

   dcache_ctrl #(.SETS(64), .WAYS(1), .MEM_LATENCY(LAT), .ADDR_W(32)) u_dut_b (
      .clk (clk), .rst_b (rst_b),
      .req_valid (b_req_valid), .req_ready (b_req_ready), .req_write (b_req_write),
      .req_addr (b_req_addr), .req_wdata (b_req_wdata), .req_byte_en (b_req_be),
      .resp_valid (b_resp_valid), .resp_rdata (b_resp_rdata),
      .mem_addr (b_mem_addr), .mem_data_in (b_mem_din), .mem_data_out (b_mem_dout),
      .mem_write_en (b_mem_we), .hit_count (b_hits), .miss_count (b_misses)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2, input logic [7:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // Memory models: combinational-enough read (updated every negedge while the address is
   // stable); a write commits only after the strobe was held LAT cycles.
   always @(negedge clk) begin
      logic [31:0] rd;
      if (a_mem_we === 1'b1) begin
         if (wb_len == 0) begin
            wb_addr = a_mem_addr;
            wb_data = pack4(a_mem_din[0], a_mem_din[1], a_mem_din[2], a_mem_din[3]);
         end
         wb_len++;
         if (wb_len == LAT) mem_a[wb_addr] = wb_data;
      end else if (wb_len != 0) begin
         wb_log.push_back('{wb_addr, wb_data, wb_len});
         wb_len = 0;
      end
      rd = mem_a.exists(a_mem_addr) ? mem_a[a_mem_addr] : 32'h0;
      for (int i = 0; i < 4; i++) a_mem_dout[i] = rd[8*i +: 8];
      rd = mem_b.exists(b_mem_addr) ? mem_b[b_mem_addr] : 32'h0;
      for (int i = 0; i < 4; i++) b_mem_dout[i] = rd[8*i +: 8];
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_b === 1'b1 && a_resp_valid === 1'b1) begin
         a_resp_cnt++;
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_resp: got %h expected no response", a_resp_rdata);
         end else begin
            e = q_a.pop_front();
            check("a_rdata", a_resp_rdata, e.rdata);
            check("a_latency", cyc - e.acc, e.lat);
            check("a_ready_low_in_respond", {31'b0, a_req_ready}, 32'h0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_b === 1'b1 && b_resp_valid === 1'b1) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_resp: got %h expected no response", b_resp_rdata);
         end else begin
            e = q_b.pop_front();
            check("b_rdata", b_resp_rdata, e.rdata);
            check("b_latency", cyc - e.acc, e.lat);
         end
      end
   end

   // Presents a request (leaving req_valid high on return) and queues the expected response.
   task automatic issue(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input int lat, input bit expect_resp);
      int  waited;
      bit  ok;
      waited = 0;
      ok     = 1'b0;
      @(negedge clk);
      if (!sel) begin
         a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
         a_req_wdata = wdata; a_req_be = be;
      end else begin
         b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr;
         b_req_wdata = wdata; b_req_be = be;
      end
      while (!ok && waited < 50) begin
         if ((sel ? b_req_ready : a_req_ready) === 1'b1) ok = 1'b1;
         else begin
            waited++;
            @(negedge clk);
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: addr %h not accepted, expected acceptance within 50 cycles", addr);
      end else if (expect_resp) begin
         if (!sel) begin
            q_a.push_back('{exp_rdata, lat, cyc});
            a_issued++;
         end else begin
            q_b.push_back('{exp_rdata, lat, cyc});
         end
      end
      @(posedge clk);
   endtask

   task automatic release_req();
      @(negedge clk);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("scoreboard_empty", q_a.size() + q_b.size(), 32'd0);
   endtask

   task automatic check_wb(input string name, input logic [31:0] addr,
                           input logic [31:0] data, input int len);
      wb_t w;
      if (wb_log.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got no writeback expected one at %h", name, addr);
      end else begin
         w = wb_log.pop_front();
         check({name, "_addr"}, w.addr, addr);
         check({name, "_data"}, w.data, data);
         check({name, "_len"}, w.len, len);
      end
   endtask

   initial begin
      int n;
      cyc = 0; checks = 0; errors = 0; a_issued = 0; a_resp_cnt = 0; wb_len = 0;
      rst_b = 1'b0;
      a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
      b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
      mem_a[32'h100] = 32'hDEADBEEF;
      mem_a[32'h300] = 32'hCAFEF00D;
      mem_a[32'h500] = 32'h55667788;
      mem_a[32'h700] = 32'h13579BDF;
      mem_a[32'h900] = 32'h2468ACE0;
      mem_b[32'h000] = 32'h0BADF00D;
      mem_b[32'h100] = 32'hFEEDFACE;

      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'b0, a_req_ready}, 32'h0);
      check("rst_resp_valid", {31'b0, a_resp_valid}, 32'h0);
      check("rst_mem_we", {31'b0, a_mem_we}, 32'h0);
      check("rst_mem_addr", a_mem_addr, 32'h0);
      check("rst_hits", a_hits, 32'h0);
      check("rst_misses", a_misses, 32'h0);
      rst_b = 1'b1;
      #1 check("ready_after_reset", {31'b0, a_req_ready}, 32'h1);

      // Cold load: clean miss
      issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 2 + LAT, 1);
      release_req();
      drain();
      check("cold_hits", a_hits, 32'd0);
      check("cold_misses", a_misses, 32'd1);
      check("cold_no_writeback", wb_log.size(), 32'd0);

      // Partial store hit, then reload hit
      issue(0, 1, 32'h100, 32'h11223344, 4'b0011, 32'hDEAD3344, 2, 1);
      release_req();
      issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD3344, 2, 1);
      release_req();
      drain();
      check("store_hits", a_hits, 32'd2);
      check("store_misses", a_misses, 32'd1);

      // Fill index 0: way1 free, then evict dirty way0
      issue(0, 0, 32'h300, 32'h0, 4'h0, 32'hCAFEF00D, 2 + LAT, 1);
      release_req();
      issue(0, 0, 32'h500, 32'h0, 4'h0, 32'h55667788, 2 + 2 * LAT, 1);
      release_req();
      drain();
      check("evict_misses", a_misses, 32'd3);
      check_wb("wb_first", 32'h100, 32'hDEAD3344, LAT);

      // Back-to-back with req_valid held; last one evicts dirty 0x300 via round-robin
      issue(0, 0, 32'h500, 32'h0, 4'h0, 32'h55667788, 2, 1);
      issue(0, 1, 32'h300, 32'hAABBCCDD, 4'b1100, 32'hAABBF00D, 2, 1);
      issue(0, 0, 32'h300, 32'h0, 4'h0, 32'hAABBF00D, 2, 1);
      issue(0, 1, 32'h700, 32'hFFFFFFFF, 4'b0000, 32'h13579BDF, 2 + 2 * LAT, 1);
      release_req();
      drain();
      check("b2b_hits", a_hits, 32'd5);
      check("b2b_misses", a_misses, 32'd4);
      check("b2b_resp_count", a_resp_cnt, a_issued);
      check_wb("wb_second", 32'h300, 32'hAABBF00D, LAT);

      // Dirty 0x500, then a miss that must write it back; reset lands mid-writeback
      issue(0, 1, 32'h500, 32'h000000FF, 4'b0001, 32'h556677FF, 2, 1);
      release_req();
      drain();
      check("pre_abort_hits", a_hits, 32'd6);
      issue(0, 0, 32'h900, 32'h0, 4'h0, 32'h0, 0, 0);
      release_req();
      n = 0;
      while (a_mem_we !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_wb_started", {31'b0, a_mem_we}, 32'h1);
      @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      check("abort_mem_we_drop", {31'b0, a_mem_we}, 32'h0);
      check("abort_req_ready", {31'b0, a_req_ready}, 32'h0);
      check("abort_hits", a_hits, 32'd0);
      check("abort_misses", a_misses, 32'd0);
      check("abort_resp_rdata", a_resp_rdata, 32'h0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      check_wb("wb_aborted", 32'h500, 32'h556677FF, 2);

      // All lines invalid after reset: both loads miss cleanly
      issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD3344, 2 + LAT, 1);
      release_req();
      drain();
      check("post_reset_misses_1", a_misses, 32'd1);
      check("post_reset_hits", a_hits, 32'd0);
      issue(0, 0, 32'h700, 32'h0, 4'h0, 32'h13579BDF, 2 + LAT, 1);
      release_req();
      drain();
      check("post_reset_misses_2", a_misses, 32'd2);

      // Direct-mapped build: alternating same-index loads always miss
      for (int i = 0; i < 4; i++) begin
         logic [31:0] addr;
         addr = (i % 2 == 0) ? 32'h000 : 32'h100;
         issue(1, 0, addr, 32'h0, 4'h0, mem_b[addr], 2 + LAT, 1);
         release_req();
         drain();
         check("dm_misses", b_misses, i + 1);
         check("dm_hits", b_hits, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
